load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: data memory word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data bus width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 15: maximum cycles to wait for mem_ready.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk (in, 1, rising-edge clock) and rst (in, 1, synchronous active-high reset).
REQ-005 SHALL have core request ports: req_valid in 1; req_store in 1 (1=store, 0=load); req_size in 2 (00 byte, 01 half, 10 word); req_unsigned in 1 (zero-extend loads); req_base in DATA_WIDTH; req_offset in 12 (signed); req_wdata in DATA_WIDTH; req_ready out 1.
REQ-006 SHALL have core response ports: rsp_valid out 1; rsp_rdata out DATA_WIDTH; rsp_err out 1.
REQ-007 SHALL have memory-side ports: mem_wd out 1; mem_rd out 1; mem_to_size out 2; mem_from_size out 2; mem_unsigned_value out 1; mem_addr_in out ADDR_WIDTH (write address); mem_addr_out out ADDR_WIDTH (read address); mem_data_in out DATA_WIDTH; mem_data_out in DATA_WIDTH; mem_ready in 1 (0 = busy).

Function
REQ-008 SHALL compute the effective address as req_base plus sign-extended req_offset, truncated to ADDR_WIDTH, and latch it on acceptance.
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-010 IDLE: SHALL drive req_ready=1 and accept on req_valid=1, latching all req_* fields. Next state: RESP with error if the request is illegal, otherwise ISSUE.
REQ-011 SHALL treat req_size=11 as illegal: rsp_err=1, no memory strobe.
REQ-012 ISSUE with mem_ready=1: SHALL pulse exactly one of mem_wd/mem_rd for one cycle, with address, size, unsigned and data driven from the latched fields. Stores go to RESP; loads go to WAIT.
REQ-013 ISSUE with mem_ready=0: SHALL increment a wait counter. When it reaches TIMEOUT_CYCLES, SHALL go to RESP with rsp_err=1 and no strobe.
REQ-014 WAIT: SHALL capture mem_data_out into rsp_rdata, then go to RESP. The memory returns registered data the cycle after mem_rd.
REQ-015 RESP: SHALL assert rsp_valid=1 for exactly one cycle, then return to IDLE.
REQ-016 req_ready SHALL be 0 in every state except IDLE. req_valid outside IDLE SHALL be ignored.
REQ-017 Latency from the acceptance edge with mem_ready=1: store rsp_valid 2 cycles later; load rsp_valid 3 cycles later.
REQ-018 rsp_rdata SHALL hold its value until the next load completes. For stores and errored requests, rsp_rdata SHALL be 0.
REQ-019 mem_wd and mem_rd SHALL never be asserted in the same cycle.
REQ-020 mem_addr_in and mem_addr_out SHALL both carry the latched address. mem_to_size and mem_from_size SHALL both carry the latched size.

Reset
REQ-021 On rst=1 at a clock edge, SHALL enter IDLE from any state, including mid-transaction; an in-flight load response is dropped.
REQ-022 Reset values: req_ready=1; rsp_valid, rsp_err, mem_wd, mem_rd = 0; rsp_rdata, wait counter, and all latched fields = 0.

Configuration
REQ-023 With macro LSU_MISALIGN_TRAP_EN defined, SHALL flag as illegal (REQ-010 path) a half access with addr[0]=1 and a word access with addr[1:0]!=00: rsp_err=1 and no strobe.
REQ-024 Without LSU_MISALIGN_TRAP_EN, SHALL perform no alignment check, and every size-legal access SHALL reach the memory.

Structure
REQ-025 SHALL place the following in shared package lsu_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state type.
REQ-026 SHALL use one combinational sub-module, lsu_req_check (address sum, size legality, alignment), instantiated once.

Verification
REQ-027 Store word: base=0x10, offset=4, wdata=0xDEADBEEF, mem_ready=1. Required: mem_wd one cycle with mem_addr_in=0x14 and to_size=10; rsp_valid 2 cycles after acceptance; rsp_err=0.
REQ-028 Signed byte load: memory returns 0x000000F0 with mem_from_size=00 and unsigned_value=0. Required: rsp_rdata=0xFFFFFFF0 (memory sign-extends); rsp_valid 3 cycles after acceptance.
REQ-029 Negative offset: base=0x20, offset=0xFFC (-4). Required: mem_addr_out=0x1C.
REQ-030 Timeout: mem_ready held 0. Required: rsp_valid with rsp_err=1 after TIMEOUT_CYCLES ISSUE cycles; no strobe ever asserted.
REQ-031 Misaligned half at address 0x3 with LSU_MISALIGN_TRAP_EN: rsp_err=1 and no strobe. Without the macro: mem_rd pulses and rsp_err=0.
REQ-032 Reset in WAIT: assert rst during a load. Required: IDLE next cycle, rsp_valid never asserted, req_ready=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings and the
// FSM state type with its legacy-compatible state constants.
package lsu_pkg;

    // Access size encodings carried on req_size / mem_to_size / mem_from_size
    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    // FSM state type and encodings
    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t ST_IDLE  = 2'd0;
    localparam lsu_state_t ST_ISSUE = 2'd1;
    localparam lsu_state_t ST_WAIT  = 2'd2;
    localparam lsu_state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/load_store_unit_if.sv
// Core-request, core-response and memory-side bundle of the load/store unit.
//   slave  : seen by the LSU (requests in, responses and memory strobes out)
//   master : seen by the core/memory environment (the reverse directions)
interface load_store_unit_if
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
);
    // core request
    logic                  req_valid;
    logic                  req_store;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [DATA_WIDTH-1:0] req_base;
    logic [11:0]           req_offset;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_ready;
    // core response
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    // memory side
    logic                  mem_wd;
    logic                  mem_rd;
    logic [1:0]            mem_to_size;
    logic [1:0]            mem_from_size;
    logic                  mem_unsigned_value;
    logic [ADDR_WIDTH-1:0] mem_addr_in;
    logic [ADDR_WIDTH-1:0] mem_addr_out;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  mem_ready;

    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_base,
               req_offset, req_wdata, mem_data_out, mem_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wd, mem_rd,
               mem_to_size, mem_from_size, mem_unsigned_value,
               mem_addr_in, mem_addr_out, mem_data_in
    );

    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_base,
               req_offset, req_wdata, mem_data_out, mem_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wd, mem_rd,
               mem_to_size, mem_from_size, mem_unsigned_value,
               mem_addr_in, mem_addr_out, mem_data_in
    );

endinterface

// File: rtl/lsu_req_check.sv
// Combinational request checker: effective address (base + sign-extended
// 12-bit offset, truncated) and legality of the access size.
// Optional macro LSU_MISALIGN_TRAP_EN additionally flags misaligned half/word.
// Ports: base_i, offset_i, size_i -> addr_c_o, illegal_c_o
module lsu_req_check
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] base_i,
    input  logic [11:0]           offset_i,
    input  logic [1:0]            size_i,
    output logic [ADDR_WIDTH-1:0] addr_c_o,
    output logic                  illegal_c_o
);

    logic [DATA_WIDTH-1:0] sum;

    // Address sum and legality
    always_comb begin
        sum         = base_i + DATA_WIDTH'($signed(offset_i));
        addr_c_o    = ADDR_WIDTH'(sum);
        illegal_c_o = (size_i == SZ_ILLEGAL);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((size_i == SZ_HALF) && addr_c_o[0]) begin
            illegal_c_o = 1'b1;
        end
        if ((size_i == SZ_WORD) && (addr_c_o[1:0] != 2'b00)) begin
            illegal_c_o = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request at a time, issues a single memory
// strobe (or traps / times out), and returns a one-cycle response.
// Ports: clk, rst (synchronous, active high), bus (load_store_unit_if.slave).
// Optional macro LSU_MISALIGN_TRAP_EN: treat misaligned half/word as illegal.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  store_q, store_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rsp_valid_q, rsp_err_q, req_ready_q;
    logic                  wd_c, rd_c;
    logic [ADDR_WIDTH-1:0] chk_addr_c;
    logic                  chk_illegal_c;

    lsu_req_check #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_req_check (
        .base_i      (bus.req_base),
        .offset_i    (bus.req_offset),
        .size_i      (bus.req_size),
        .addr_c_o    (chk_addr_c),
        .illegal_c_o (chk_illegal_c)
    );

    // Next-state and strobe logic; strobes are only ever raised in ISSUE and
    // selected by the latched direction, so they are mutually exclusive.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        store_d = store_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        wd_c    = 1'b0;
        rd_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    store_d = bus.req_store;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    addr_d  = chk_addr_c;
                    wdata_d = bus.req_wdata;
                    cnt_d   = '0;
                    err_d   = chk_illegal_c;
                    if (chk_illegal_c) begin
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (bus.mem_ready) begin
                    if (store_q) begin
                        wd_c    = 1'b1;
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else begin
                        rd_c    = 1'b1;
                        state_d = ST_WAIT;
                    end
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                    if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                // memory data is registered: valid the cycle after mem_rd
                rdata_d = bus.mem_data_out;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched-field registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            store_q     <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            store_q     <= store_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= (state_d == ST_RESP);
            rsp_err_q   <= (state_d == ST_RESP) && err_d;
            req_ready_q <= (state_d == ST_IDLE);
        end
    end

    assign bus.req_ready          = req_ready_q;
    assign bus.rsp_valid          = rsp_valid_q;
    assign bus.rsp_err            = rsp_err_q;
    assign bus.rsp_rdata          = rdata_q;
    assign bus.mem_wd             = wd_c;
    assign bus.mem_rd             = rd_c;
    assign bus.mem_to_size        = size_q;
    assign bus.mem_from_size      = size_q;
    assign bus.mem_unsigned_value = uns_q;
    assign bus.mem_addr_in        = addr_q;
    assign bus.mem_addr_out       = addr_q;
    assign bus.mem_data_in        = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a registered,
// size-extending memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    load_store_unit #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int n_wd     = 0;
    int n_rd     = 0;
    int n_both   = 0;
    logic [31:0] mem_raw;

    function automatic logic [31:0] mem_ext(input logic [31:0] raw,
                                            input logic [1:0] sz,
                                            input logic uns);
        case (sz)
            SZ_BYTE: mem_ext = uns ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            SZ_HALF: mem_ext = uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: mem_ext = raw;
        endcase
    endfunction

    // memory model and strobe monitor
    always @(posedge clk) begin
        if (bus.mem_wd) n_wd <= n_wd + 1;
        if (bus.mem_rd) n_rd <= n_rd + 1;
        if (bus.mem_wd && bus.mem_rd) n_both <= n_both + 1;
        if (rst) bus.mem_data_out <= '0;
        else if (bus.mem_rd)
            bus.mem_data_out <= mem_ext(mem_raw, bus.mem_from_size, bus.mem_unsigned_value);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic st, input logic [1:0] sz, input logic un,
                          input logic [31:0] base, input logic [11:0] off,
                          input logic [31:0] wd);
        bus.req_store    = st;
        bus.req_size     = sz;
        bus.req_unsigned = un;
        bus.req_base     = base;
        bus.req_offset   = off;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        tick();
        bus.req_valid    = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while ((bus.rsp_valid !== 1'b1) && (n < 40)) begin
            tick();
            n++;
        end
    endtask

    int n;
    int w0, r0;

    initial begin
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_base = '0; bus.req_offset = '0;
        bus.req_wdata = '0; bus.mem_ready = 1'b1; mem_raw = '0;
        rst = 1'b1;
        tick(); tick();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        chk("rst_strobes",   32'({bus.mem_wd, bus.mem_rd}), 32'd0);
        chk("rst_rdata",     bus.rsp_rdata, 32'd0);
        chk("rst_addr",      32'(bus.mem_addr_in), 32'd0);
        rst = 1'b0;
        tick();

        // store word 0x10+4
        w0 = n_wd; r0 = n_rd;
        do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 12'h004, 32'hDEADBEEF);
        chk("st_ready_low", 32'(bus.req_ready), 32'd0);
        chk("st_wd",        32'(bus.mem_wd), 32'd1);
        chk("st_rd",        32'(bus.mem_rd), 32'd0);
        chk("st_addr",      32'(bus.mem_addr_in), 32'h14);
        chk("st_to_size",   32'(bus.mem_to_size), 32'(SZ_WORD));
        chk("st_wdata",     bus.mem_data_in, 32'hDEADBEEF);
        wait_rsp(n);
        chk("st_latency",   n, 1);
        chk("st_err",       32'(bus.rsp_err), 32'd0);
        chk("st_rdata",     bus.rsp_rdata, 32'd0);
        chk("st_nwd",       n_wd - w0, 1);
        chk("st_nrd",       n_rd - r0, 0);
        tick();
        chk("st_valid_1cyc", 32'(bus.rsp_valid), 32'd0);
        chk("st_ready_back", 32'(bus.req_ready), 32'd1);

        // signed byte load
        mem_raw = 32'h000000F0;
        do_req(1'b0, SZ_BYTE, 1'b0, 32'h40, 12'h000, 32'h0);
        chk("lb_rd",       32'(bus.mem_rd), 32'd1);
        chk("lb_wd",       32'(bus.mem_wd), 32'd0);
        chk("lb_from_sz",  32'(bus.mem_from_size), 32'(SZ_BYTE));
        chk("lb_uns",      32'(bus.mem_unsigned_value), 32'd0);
        chk("lb_addr",     32'(bus.mem_addr_out), 32'h40);
        wait_rsp(n);
        chk("lb_latency",  n, 2);
        chk("lb_rdata",    bus.rsp_rdata, 32'hFFFFFFF0);
        chk("lb_err",      32'(bus.rsp_err), 32'd0);
        tick();
        chk("lb_hold",     bus.rsp_rdata, 32'hFFFFFFF0);

        // store half with memory busy for three cycles
        bus.mem_ready = 1'b0;
        w0 = n_wd;
        do_req(1'b1, SZ_HALF, 1'b0, 32'h200, 12'h002, 32'h0000CAFE);
        chk("sb_busy_wd", 32'(bus.mem_wd), 32'd0);
        tick(); tick(); tick();
        bus.mem_ready = 1'b1;
        #1;
        chk("sb_wd",      32'(bus.mem_wd), 32'd1);
        chk("sb_addr",    32'(bus.mem_addr_in), 32'h202);
        chk("sb_to_size", 32'(bus.mem_to_size), 32'(SZ_HALF));
        wait_rsp(n);
        chk("sb_latency", n, 1);
        chk("sb_rdata_zero", bus.rsp_rdata, 32'd0);
        chk("sb_nwd",     n_wd - w0, 1);
        tick();

        // negative offset word load
        mem_raw = 32'h12345678;
        do_req(1'b0, SZ_WORD, 1'b0, 32'h20, 12'hFFC, 32'h0);
        chk("neg_addr_out", 32'(bus.mem_addr_out), 32'h1C);
        chk("neg_addr_in",  32'(bus.mem_addr_in), 32'h1C);
        wait_rsp(n);
        chk("neg_latency",  n, 2);
        chk("neg_rdata",    bus.rsp_rdata, 32'h12345678);
        tick();

        // illegal size
        w0 = n_wd; r0 = n_rd;
        do_req(1'b0, SZ_ILLEGAL, 1'b0, 32'h80, 12'h000, 32'h0);
        wait_rsp(n);
        chk("ill_latency", n, 0);
        chk("ill_err",     32'(bus.rsp_err), 32'd1);
        chk("ill_rdata",   bus.rsp_rdata, 32'd0);
        chk("ill_strobes", (n_wd - w0) + (n_rd - r0), 0);
        tick();
        chk("ill_err_clr", 32'(bus.rsp_err), 32'd0);

        // unsigned half load
        mem_raw = 32'h00008001;
        do_req(1'b0, SZ_HALF, 1'b1, 32'h100, 12'h000, 32'h0);
        chk("lhu_uns",   32'(bus.mem_unsigned_value), 32'd1);
        wait_rsp(n);
        chk("lhu_rdata", bus.rsp_rdata, 32'h00008001);
        tick();

        // timeout
        bus.mem_ready = 1'b0;
        w0 = n_wd; r0 = n_rd;
        do_req(1'b0, SZ_WORD, 1'b0, 32'h300, 12'h000, 32'h0);
        wait_rsp(n);
        chk("to_latency", n, int'(TO));
        chk("to_err",     32'(bus.rsp_err), 32'd1);
        chk("to_rdata",   bus.rsp_rdata, 32'd0);
        chk("to_strobes", (n_wd - w0) + (n_rd - r0), 0);
        tick();
        bus.mem_ready = 1'b1;

        // misaligned half at 0x3
        mem_raw = 32'h00001234;
        w0 = n_wd; r0 = n_rd;
        do_req(1'b0, SZ_HALF, 1'b0, 32'h3, 12'h000, 32'h0);
        wait_rsp(n);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_err",     32'(bus.rsp_err), 32'd1);
        chk("mis_strobes", (n_wd - w0) + (n_rd - r0), 0);
`else
        chk("mis_err",     32'(bus.rsp_err), 32'd0);
        chk("mis_nrd",     n_rd - r0, 1);
        chk("mis_rdata",   bus.rsp_rdata, 32'h00001234);
`endif
        tick();

        // reset while waiting for load data
        mem_raw = 32'hA5A5A5A5;
        do_req(1'b0, SZ_WORD, 1'b0, 32'h400, 12'h000, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw_ready",  32'(bus.req_ready), 32'd1);
        chk("rw_valid",  32'(bus.rsp_valid), 32'd0);
        chk("rw_rdata",  bus.rsp_rdata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rw_no_valid", 32'(bus.rsp_valid), 32'd0);
        end

        chk("never_both_strobes", n_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
